// File: rtl/gamma_lut_pkg.sv
// Shared definitions for the programmable gamma lookup table writer:
// writer FSM encoding and default table geometry.
package gamma_lut_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

endpackage

// File: rtl/gamma_lut_bank_ram.sv
// Double-bank table storage: 2*DEPTH x DATA_W simple dual-port RAM addressed
// by {bank, index}, synchronous write, registered read address.
module gamma_lut_bank_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [ADDR_W-1:0] rd_index_p1,
  output logic [DATA_W-1:0] rd_data
);

  localparam int WORDS = 2 * (2 ** ADDR_W);

  logic [DATA_W-1:0] mem [WORDS];
  logic [ADDR_W:0]   rd_addr_p1;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Stage p0 -> p1: bank and index are captured together so a bank swap
  // never splits a read across two tables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_p1 <= '0;
    end else begin
      rd_addr_p1 <= rd_addr;
    end
  end

  assign rd_data     = mem[rd_addr_p1];
  assign rd_index_p1 = rd_addr_p1[ADDR_W-1:0];

endmodule

// File: rtl/gamma_lut_writer.sv
// Programmable gamma table: loads a curve from the config stream into the
// shadow bank and swaps it into the one-cycle-latency pixel read path at frame start.
module gamma_lut_writer
  import gamma_lut_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              load_busy,
  output logic              lut_valid
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_idx, wr_idx_nxt;
  logic              active_bank, active_bank_nxt;
  logic              lut_valid_nxt;
  logic              we;

  logic              vld_p1;
  logic [ADDR_W-1:0] rd_index_p1;
  logic [DATA_W-1:0] ram_data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_idx      <= '0;
      active_bank <= 1'b0;
      lut_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_idx      <= wr_idx_nxt;
      active_bank <= active_bank_nxt;
      lut_valid   <= lut_valid_nxt;
    end
  end

  // A restart always wins: it discards any pending swap and any beat
  // presented in the same cycle, and rewinds the shadow index to 0.
  always_comb begin
    state_nxt       = state;
    wr_idx_nxt      = wr_idx;
    active_bank_nxt = active_bank;
    lut_valid_nxt   = lut_valid;
    we              = 1'b0;
    cfg_ready       = (state == ST_LOAD);
    load_busy       = (state != ST_IDLE);
    if (cfg_start) begin
      state_nxt  = ST_LOAD;
      wr_idx_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_LOAD: begin
          if (cfg_valid) begin
            we         = 1'b1;
            wr_idx_nxt = wr_idx + 1'b1;
            if (wr_idx == IDX_LAST) begin
              state_nxt = ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            active_bank_nxt = ~active_bank;
            lut_valid_nxt   = 1'b1;
            state_nxt       = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  gamma_lut_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .wr_addr     ({~active_bank, wr_idx}),
    .wr_data     (cfg_data),
    .rd_addr     ({active_bank, pix_addr}),
    .rd_index_p1 (rd_index_p1),
    .rd_data     (ram_data_p1)
  );

  // Stage p0 -> p1: table-valid flag travels with the registered read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= lut_valid;
    end
  end

  assign pix_data = vld_p1 ? ram_data_p1 : DATA_W'(rd_index_p1);

endmodule

// File: tb/tb_gamma_lut_writer.sv
// Directed self-checking bench for gamma_lut_writer: bypass, load/swap timing,
// handshake gaps, restart and frame_start corner cases, async reset.
module tb_gamma_lut_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       frame_start;
  logic [7:0] pix_addr;
  logic [7:0] pix_data;
  logic       load_busy;
  logic       lut_valid;

  int checks = 0;
  int errors = 0;

  gamma_lut_writer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .frame_start (frame_start),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .load_busy   (load_busy),
    .lut_valid   (lut_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] curve(input int mode, input int i);
    logic [7:0] idx;
    idx = 8'(i);
    case (mode)
      0:       curve = 8'd255 - idx;
      1:       curve = idx ^ 8'h5A;
      2:       curve = 8'(i * 7 + 3);
      default: curve = 8'(i + 100);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    pix_addr = a;
    tick();
    chk(tag, pix_data, exp);
  endtask

  // Streams entries [0, count) of the given curve; optional random gaps and
  // an optional frame_start on the final accepted beat.
  task automatic load(input int mode, input int count, input bit gaps, input bit fs_last);
    int  i;
    int  budget;
    bit  acc;
    i = 0;
    budget = 0;
    pulse_start();
    while (i < count && budget < 4000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'hEE;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = curve(mode, i);
      end
      acc = cfg_valid && cfg_ready;
      frame_start = fs_last && acc && (i == 255);
      tick();
      frame_start = 1'b0;
      if (acc) i++;
      budget++;
    end
    cfg_valid = 1'b0;
    chk("load_count", i, count);
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = 8'h00;
    frame_start = 1'b0;
    pix_addr    = 8'h00;
    repeat (3) tick();
    chk("rst_pix_data", pix_data, 0);
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_load_busy", load_busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    rst_n = 1'b1;
    tick();

    // identity bypass before any table
    for (int a = 0; a < 256; a++) rd(8'(a), 8'(a), "bypass");
    chk("bypass_lut_valid", lut_valid, 0);
    chk("idle_cfg_ready", cfg_ready, 0);

    // inverted curve, then swap
    load(0, 256, 1'b0, 1'b0);
    chk("pend_busy", load_busy, 1);
    chk("pend_ready", cfg_ready, 0);
    pulse_frame();
    chk("swap_busy", load_busy, 0);
    chk("swap_valid", lut_valid, 1);
    rd(8'd10, 8'd245, "inv_10");
    rd(8'd0, 8'd255, "inv_0");
    rd(8'd255, 8'd0, "inv_255");

    // second table held pending for 100 cycles with cfg_valid asserted
    load(1, 256, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hEE;
    for (int k = 0; k < 100; k++) begin
      rd(8'd10, 8'd245, "hold_old");
      if (k % 25 == 0) chk("hold_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    pix_addr = 8'd10;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap_cycle_old", pix_data, 245);
    tick();
    chk("after_swap_new", pix_data, 80);
    for (int a = 0; a < 256; a++) rd(8'(a), curve(1, a), "tbl1");

    // random gaps, cfg_valid held in PENDING, no write past index 255
    load(2, 256, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hEE;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("pend_gap_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    pulse_frame();
    for (int a = 0; a < 256; a++) rd(8'(a), curve(2, a), "tbl2");

    // frame_start mid-load is ignored; restart and reload
    load(0, 100, 1'b0, 1'b0);
    pulse_frame();
    chk("midload_busy", load_busy, 1);
    rd(8'd10, 8'd73, "midload_old");
    load(3, 256, 1'b0, 1'b1);
    chk("fs_last_busy", load_busy, 1);
    rd(8'd10, 8'd73, "fs_last_old");
    pulse_frame();
    chk("reload_idle", load_busy, 0);
    for (int a = 0; a < 256; a++) rd(8'(a), curve(3, a), "tbl3");

    // cfg_start beats frame_start in PENDING
    load(1, 256, 1'b0, 1'b0);
    cfg_start = 1'b1;
    frame_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    frame_start = 1'b0;
    chk("restart_busy", load_busy, 1);
    chk("restart_ready", cfg_ready, 1);
    rd(8'd10, 8'd110, "restart_noswap");

    // asynchronous reset while PENDING
    load(0, 256, 1'b0, 1'b0);
    chk("pre_rst_pend", cfg_ready, 0);
    pix_addr = 8'd77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pix_data", pix_data, 0);
    chk("arst_lut_valid", lut_valid, 0);
    chk("arst_busy", load_busy, 0);
    chk("arst_ready", cfg_ready, 0);
    tick();
    rst_n = 1'b1;
    rd(8'd37, 8'd37, "post_rst_bypass");
    rd(8'd200, 8'd200, "post_rst_bypass");
    chk("post_rst_valid", lut_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
